// File: rtl/com_op_code_pkg.sv
// Op-code indices (decoder output order) and state encoding shared by the
// op-code sequencer and its priority encoder.
package com_op_code_pkg;

  localparam int N_OP = 15;

  localparam int OP_W_RESET        = 0;
  localparam int OP_W_ENABLE       = 1;
  localparam int OP_W_DISABLE      = 2;
  localparam int OP_W_CONFIG       = 3;
  localparam int OP_W_CALIBRATE    = 4;
  localparam int OP_W_ARM          = 5;
  localparam int OP_W_TRIGGER      = 6;
  localparam int OP_W_READ         = 7;
  localparam int OP_W_WRITE        = 8;
  localparam int OP_W_LOAD         = 9;
  localparam int OP_W_STORE        = 10;
  localparam int OP_W_SYNC         = 11;
  localparam int OP_W_FLUSH        = 12;
  localparam int OP_W_STATUS_CLEAR = 13;
  localparam int OP_W_EXECUTE      = 14;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    SEQ_IDLE  = ST_IDLE,
    SEQ_START = ST_START,
    SEQ_WAIT  = ST_WAIT,
    SEQ_DONE  = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/com_op_code_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 has the highest priority.
module com_op_code_prio_enc
  import com_op_code_pkg::*;
#(
  parameter int N_OP = 15
) (
  input  logic [N_OP-1:0] req_i,
  output logic [3:0]      idx_o,
  output logic            valid_o
);

  always_comb begin
    idx_o   = 4'd0;
    valid_o = |req_i;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = N_OP - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/com_op_code_sequencer.sv
// Queues decoder op-code strobes and dispatches them one at a time to the
// datapath over a start/done handshake, with per-op timeout and sticky status.
//
//   state | meaning
//   IDLE  | waiting for a pending request; grants the lowest pending index
//   START | one-cycle op_start pulse, timeout counter cleared
//   WAIT  | waiting for op_done / op_error, or timeout expiry
//   DONE  | records last_op and, on the done path, status_done
module com_op_code_sequencer
  import com_op_code_pkg::*;
#(
  parameter int          N_OP           = 15,
  parameter int          TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32'h0000_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_OP-1:0] op_code_req,
  output logic            op_start,
  output logic [3:0]      op_sel,
  input  logic            op_done,
  input  logic            op_error,
  output logic            busy,
  output logic [N_OP-1:0] pending,
  output logic            status_done,
  output logic            status_error,
  output logic            status_timeout,
  output logic [3:0]      last_op
);

  localparam logic [TIMEOUT_W-1:0] TC_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t           state_q, state_d;
  logic [N_OP-1:0]      pending_q, pending_d;
  logic [N_OP-1:0]      req_eff, grant_clr;
  logic [3:0]           op_sel_q, op_sel_d;
  logic [3:0]           last_op_q, last_op_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 op_start_q, op_start_d;
  logic                 busy_q, busy_d;
  logic                 done_path_q, done_path_d;
  logic                 st_done_q, st_done_d;
  logic                 st_err_q, st_err_d;
  logic                 st_to_q, st_to_d;
  logic [3:0]           grant_idx;
  logic                 grant_vld;
  logic                 abort, clear_req, set_done, set_err, set_to;

  com_op_code_prio_enc #(
    .N_OP (N_OP)
  ) u_prio_enc (
    .req_i   (pending_q),
    .idx_o   (grant_idx),
    .valid_o (grant_vld)
  );

  always_comb begin
    abort     = op_code_req[OP_W_RESET] && (state_q != SEQ_IDLE);
    clear_req = op_code_req[OP_W_STATUS_CLEAR];
    req_eff   = op_code_req;
    req_eff[OP_W_STATUS_CLEAR] = 1'b0;
    grant_clr   = '0;
    state_d     = state_q;
    op_sel_d    = op_sel_q;
    last_op_d   = last_op_q;
    cnt_d       = cnt_q;
    done_path_d = done_path_q;
    set_done    = 1'b0;
    set_err     = 1'b0;
    set_to      = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (grant_vld) begin
          op_sel_d             = grant_idx;
          grant_clr[grant_idx] = 1'b1;
          state_d              = SEQ_START;
        end
      end
      SEQ_START: begin
        cnt_d   = '0;
        state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (op_error) begin
          set_err     = 1'b1;
          done_path_d = 1'b0;
          state_d     = SEQ_DONE;
        end else if (op_done) begin
          done_path_d = 1'b1;
          state_d     = SEQ_DONE;
        end else if (cnt_q == TC_LAST) begin
          set_to    = 1'b1;
          last_op_d = op_sel_q;
          state_d   = SEQ_IDLE;
        end
      end
      SEQ_DONE: begin
        last_op_d = op_sel_q;
        set_done  = done_path_q;
        state_d   = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Set wins over grant-clear, so a re-request of the granted op stays queued.
    pending_d = (pending_q & ~grant_clr) | req_eff;

    if (abort) begin
      state_d   = SEQ_IDLE;
      pending_d = '0;
      pending_d[OP_W_RESET] = 1'b1;
      last_op_d = last_op_q;
      set_done  = 1'b0;
      set_err   = 1'b0;
      set_to    = 1'b0;
    end

    st_done_d  = set_done | (st_done_q & ~clear_req);
    st_err_d   = set_err  | (st_err_q  & ~clear_req);
    st_to_d    = set_to   | (st_to_q   & ~clear_req);
    op_start_d = (state_d == SEQ_START);
    busy_d     = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEQ_IDLE;
      pending_q   <= '0;
      op_sel_q    <= 4'd0;
      last_op_q   <= 4'd0;
      cnt_q       <= '0;
      op_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_path_q <= 1'b0;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      st_to_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      op_sel_q    <= op_sel_d;
      last_op_q   <= last_op_d;
      cnt_q       <= cnt_d;
      op_start_q  <= op_start_d;
      busy_q      <= busy_d;
      done_path_q <= done_path_d;
      st_done_q   <= st_done_d;
      st_err_q    <= st_err_d;
      st_to_q     <= st_to_d;
    end
  end

  assign op_start       = op_start_q;
  assign op_sel         = op_sel_q;
  assign busy           = busy_q;
  assign pending        = pending_q;
  assign status_done    = st_done_q;
  assign status_error   = st_err_q;
  assign status_timeout = st_to_q;
  assign last_op        = last_op_q;

endmodule

// File: tb/tb_com_op_code_sequencer.sv
// Directed bench for the op-code sequencer, run with an 8-cycle timeout.
module tb_com_op_code_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] op_code_req;
  logic        op_start;
  logic [3:0]  op_sel;
  logic        op_done;
  logic        op_error;
  logic        busy;
  logic [14:0] pending;
  logic        status_done;
  logic        status_error;
  logic        status_timeout;
  logic [3:0]  last_op;

  int n_cmp = 0;
  int n_bad = 0;

  com_op_code_sequencer #(
    .N_OP           (15),
    .TIMEOUT_W      (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .op_code_req    (op_code_req),
    .op_start       (op_start),
    .op_sel         (op_sel),
    .op_done        (op_done),
    .op_error       (op_error),
    .busy           (busy),
    .pending        (pending),
    .status_done    (status_done),
    .status_error   (status_error),
    .status_timeout (status_timeout),
    .last_op        (last_op)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; op_code_req = '0; op_done = 1'b0; op_error = 1'b0;
    tick(2);
    n_cmp++; if (op_start !== 1'b0) begin n_bad++; $display("FAIL rst_op_start: got %b want 0", op_start); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (pending !== 15'h0) begin n_bad++; $display("FAIL rst_pending: got %h want 0000", pending); end
    n_cmp++; if ({status_done, status_error, status_timeout} !== 3'b000) begin n_bad++; $display("FAIL rst_status: got %b want 000", {status_done, status_error, status_timeout}); end
    n_cmp++; if ({op_sel, last_op} !== 8'h00) begin n_bad++; $display("FAIL rst_sel_last: got %h want 00", {op_sel, last_op}); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single_op;
    op_code_req = 15'h0020;                       // cycle 0
    tick(); op_code_req = '0;                     // cycle 1
    n_cmp++; if (pending !== 15'h0020) begin n_bad++; $display("FAIL single_pend: got %h want 0020", pending); end
    n_cmp++; if (op_start !== 1'b0) begin n_bad++; $display("FAIL single_nostart_c1: got %b want 0", op_start); end
    tick();                                       // cycle 2: START
    n_cmp++; if (op_start !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b want 1", op_start); end
    n_cmp++; if (op_sel !== 4'd5) begin n_bad++; $display("FAIL single_sel: got %0d want 5", op_sel); end
    n_cmp++; if (pending !== 15'h0) begin n_bad++; $display("FAIL single_pend_clr: got %h want 0000", pending); end
    tick();                                       // cycle 3: WAIT 1
    n_cmp++; if (op_start !== 1'b0) begin n_bad++; $display("FAIL single_start_pulse: got %b want 0", op_start); end
    tick(3);                                      // cycle 6: WAIT 4
    op_done = 1'b1;
    tick(); op_done = 1'b0;                       // cycle 7: DONE
    n_cmp++; if ({busy, status_done} !== 2'b10) begin n_bad++; $display("FAIL single_done_state: got %b want 10", {busy, status_done}); end
    tick();                                       // cycle 8: IDLE
    n_cmp++; if (status_done !== 1'b1) begin n_bad++; $display("FAIL single_status_done: got %b want 1", status_done); end
    n_cmp++; if (last_op !== 4'd5) begin n_bad++; $display("FAIL single_last_op: got %0d want 5", last_op); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_low: got %b want 0", busy); end
  endtask

  task automatic test_priority;
    op_code_req = 15'h0204;
    tick(); op_code_req = '0;                     // cycle 1
    n_cmp++; if (pending !== 15'h0204) begin n_bad++; $display("FAIL prio_pend0: got %h want 0204", pending); end
    tick();                                       // cycle 2: START op 2
    n_cmp++; if ({op_start, op_sel} !== 5'h12) begin n_bad++; $display("FAIL prio_first: got start/sel %h want 12", {op_start, op_sel}); end
    n_cmp++; if (pending !== 15'h0200) begin n_bad++; $display("FAIL prio_pend1: got %h want 0200", pending); end
    tick(); op_done = 1'b1;                       // cycle 3: WAIT
    tick(); op_done = 1'b0;                       // cycle 4: DONE
    tick();                                       // cycle 5: IDLE
    n_cmp++; if (last_op !== 4'd2) begin n_bad++; $display("FAIL prio_last1: got %0d want 2", last_op); end
    tick();                                       // cycle 6: START op 9
    n_cmp++; if ({op_start, op_sel} !== 5'h19) begin n_bad++; $display("FAIL prio_second: got start/sel %h want 19", {op_start, op_sel}); end
    n_cmp++; if (pending !== 15'h0) begin n_bad++; $display("FAIL prio_pend2: got %h want 0000", pending); end
    tick(); op_done = 1'b1;
    tick(); op_done = 1'b0;
    tick();
    n_cmp++; if ({busy, last_op} !== 5'h09) begin n_bad++; $display("FAIL prio_end: got busy/last %h want 09", {busy, last_op}); end
  endtask

  task automatic test_requeue;
    op_code_req = 15'h0080;
    tick(); op_code_req = '0;                     // cycle 1
    tick();                                       // cycle 2: START op 7
    tick(); op_code_req = 15'h0080;               // cycle 3: WAIT, re-request
    tick(); op_code_req = '0; op_done = 1'b1;     // cycle 4: WAIT, done
    n_cmp++; if (pending !== 15'h0080) begin n_bad++; $display("FAIL requeue_pend: got %h want 0080", pending); end
    tick(); op_done = 1'b0;                       // cycle 5: DONE
    tick();                                       // cycle 6: IDLE
    n_cmp++; if (op_start !== 1'b0) begin n_bad++; $display("FAIL requeue_early: got %b want 0", op_start); end
    tick();                                       // cycle 7: START again
    n_cmp++; if ({op_start, op_sel} !== 5'h17) begin n_bad++; $display("FAIL requeue_restart: got start/sel %h want 17", {op_start, op_sel}); end
    tick(); op_done = 1'b1;
    tick(); op_done = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    op_code_req = 15'h2000;
    tick(); op_code_req = '0;
    n_cmp++; if ({status_done, status_error, status_timeout} !== 3'b000) begin n_bad++; $display("FAIL to_preclear: got %b want 000", {status_done, status_error, status_timeout}); end
    op_code_req = 15'h0008;                       // cycle 0
    tick(); op_code_req = '0;                     // cycle 1
    tick(2);                                      // cycle 3: WAIT entry
    tick(7);                                      // cycle 10
    n_cmp++; if ({busy, status_timeout} !== 2'b10) begin n_bad++; $display("FAIL to_early: got busy/to %b want 10", {busy, status_timeout}); end
    tick();                                       // cycle 11 = w + 8
    n_cmp++; if ({busy, status_timeout} !== 2'b01) begin n_bad++; $display("FAIL to_expire: got busy/to %b want 01", {busy, status_timeout}); end
    n_cmp++; if (status_done !== 1'b0) begin n_bad++; $display("FAIL to_no_done: got %b want 0", status_done); end
    n_cmp++; if (last_op !== 4'd3) begin n_bad++; $display("FAIL to_last_op: got %0d want 3", last_op); end
    tick();
  endtask

  task automatic test_err_done_clear;
    op_code_req = 15'h0002;
    tick(); op_code_req = '0;
    tick();                                       // START
    tick(); op_done = 1'b1; op_error = 1'b1;      // WAIT
    tick(); op_done = 1'b0; op_error = 1'b0;      // DONE
    n_cmp++; if (status_error !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1", status_error); end
    tick();                                       // IDLE
    n_cmp++; if ({status_done, status_error, status_timeout} !== 3'b011) begin n_bad++; $display("FAIL err_collision: got %b want 011", {status_done, status_error, status_timeout}); end
    n_cmp++; if (last_op !== 4'd1) begin n_bad++; $display("FAIL err_last_op: got %0d want 1", last_op); end
    op_code_req = 15'h2000;
    tick(); op_code_req = '0;
    n_cmp++; if ({status_done, status_error, status_timeout} !== 3'b000) begin n_bad++; $display("FAIL clr_flags: got %b want 000", {status_done, status_error, status_timeout}); end
    n_cmp++; if ({op_start, busy, pending} !== 17'h0) begin n_bad++; $display("FAIL clr_not_queued: got %h want 00000", {op_start, busy, pending}); end
    tick();
    n_cmp++; if ({op_start, busy} !== 2'b00) begin n_bad++; $display("FAIL clr_no_dispatch: got %b want 00", {op_start, busy}); end
  endtask

  task automatic test_abort;
    op_code_req = 15'h0140;
    tick(); op_code_req = '0;                     // cycle 1
    tick();                                       // cycle 2: START op 6
    n_cmp++; if (op_sel !== 4'd6) begin n_bad++; $display("FAIL abort_sel6: got %0d want 6", op_sel); end
    tick(); op_code_req = 15'h0001;               // cycle 3: WAIT, abort
    tick(); op_code_req = '0;                     // cycle 4
    n_cmp++; if ({busy, op_start} !== 2'b00) begin n_bad++; $display("FAIL abort_idle: got %b want 00", {busy, op_start}); end
    n_cmp++; if (pending !== 15'h0001) begin n_bad++; $display("FAIL abort_pend: got %h want 0001", pending); end
    n_cmp++; if (last_op !== 4'd1) begin n_bad++; $display("FAIL abort_last_kept: got %0d want 1", last_op); end
    tick();                                       // cycle 5: START op 0
    n_cmp++; if ({op_start, op_sel} !== 5'h10) begin n_bad++; $display("FAIL abort_dispatch0: got start/sel %h want 10", {op_start, op_sel}); end
    tick(); op_done = 1'b1;
    tick(); op_done = 1'b0;
    tick();
    n_cmp++; if ({busy, pending, last_op} !== 20'h0) begin n_bad++; $display("FAIL abort_drop8: got %h want 00000", {busy, pending, last_op}); end
    tick(2);
    n_cmp++; if ({busy, op_start} !== 2'b00) begin n_bad++; $display("FAIL abort_stay_idle: got %b want 00", {busy, op_start}); end
  endtask

  task automatic test_async_reset;
    op_code_req = 15'h0010;
    tick(); op_code_req = '0;
    tick(2);                                      // WAIT
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({op_start, busy, pending, op_sel, last_op} !== 25'h0) begin n_bad++; $display("FAIL arst_outputs: got %h want 0000000", {op_start, busy, pending, op_sel, last_op}); end
    n_cmp++; if ({status_done, status_error, status_timeout} !== 3'b000) begin n_bad++; $display("FAIL arst_status: got %b want 000", {status_done, status_error, status_timeout}); end
    tick(2);
    reset = 1'b0;
    op_done = 1'b1;
    tick(); op_done = 1'b0;
    tick();
    n_cmp++; if ({busy, op_start, status_done, last_op} !== 7'h0) begin n_bad++; $display("FAIL arst_late_done: got %h want 00", {busy, op_start, status_done, last_op}); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_priority();
    test_requeue();
    test_timeout();
    test_err_done_clear();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/com_op_code_sequencer.md
# com_op_code_sequencer

Command sequencer placed directly after the op-code decoder. It latches the decoder's one-cycle op-code strobes into a pending set and dispatches them one at a time to the datapath through a start/done handshake, using fixed priority. A per-operation timeout guards each dispatch. Outcomes are reported as sticky status flags. `w_reset` aborts any in-flight operation, and `w_status_clear` is handled locally.

## Interface
- `N_OP`, default 15: number of op codes; the bit index is the op-code index from the package.
- `TIMEOUT_W`, default 16: width of the timeout counter.
- `TIMEOUT_CYCLES`, default 16'hFFFF: number of WAIT cycles before timeout; legal range 2 to 2^TIMEOUT_W−1.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-high reset.
- `op_code_req` input N_OP: one-cycle decoder strobes, already gated by device-ID enable.
- `op_start` output 1: one-cycle dispatch pulse.
- `op_sel` output 4: index of the op being dispatched or executed; held from START through DONE.
- `op_done` input 1: the datapath finished `op_sel`.
- `op_error` input 1: the datapath failed `op_sel`.
- `busy` output 1: high whenever the state is not IDLE.
- `pending` output N_OP: the queued-request register.
- `status_done` output 1: sticky; set on the done path.
- `status_error` output 1: sticky; set when `op_error` is seen in WAIT.
- `status_timeout` output 1: sticky; set when the timeout expires.
- `last_op` output 4: index of the last op that left WAIT.

## Operation
- Reset: every output is 0 and the state is IDLE. Any in-flight handshake is abandoned; no done/error is recorded.
- Pending register, each cycle: `pending <= (pending & ~grant_clr) | req_eff`.
  - `req_eff` is `op_code_req` with bit OP_W_STATUS_CLEAR masked off.
  - If a request and a grant-clear hit the same bit in the same cycle, the set wins.
- Status clear: `op_code_req[OP_W_STATUS_CLEAR]` clears all three sticky flags on the next edge.
  - It is never queued or dispatched.
  - If a flag-set event happens in the same cycle, the set wins.
- Abort: `op_code_req[OP_W_RESET]` in START, WAIT or DONE forces the next state to IDLE.
  - `pending` becomes exactly {OP_W_RESET}.
  - The aborted op records nothing, and `last_op` is unchanged.
  - In IDLE, the same request is simply queued.
- FSM states: IDLE, START, WAIT, DONE.
  - **IDLE:** if `pending != 0`, grant the lowest set index (index 0 has highest priority) via the priority encoder. Register it into `op_sel`, clear its pending bit (`grant_clr`), and go to START.
  - **START:** `op_start = 1` for this cycle only. Clear the timeout counter. Go to WAIT. `op_done` and `op_error` are ignored in this state.
  - **WAIT:** the counter increments each cycle. Exits, in priority order:
    - `op_error` → set `status_error`, go to DONE.
    - `op_done` → go to DONE; `status_done` is set on entering DONE.
    - counter == TIMEOUT_CYCLES−1 → set `status_timeout`, go to IDLE directly.
    - If `op_error` and `op_done` arrive together, error wins; `status_done` is not set.
    - If `op_done` arrives in the same cycle as expiry, done wins.
  - **DONE:** `last_op <= op_sel`. Set `status_done` on the done path only. Go to IDLE.
  - Timeout exit: `last_op` is also updated on the timeout exit.
- A new request for the op that is currently executing re-queues it; it is dispatched again afterwards.
- Repeated requests for the same op while it is still pending merge into one dispatch.
- Request bits at index ≥ 15 do not exist when N_OP=15.

## Timing
- Request at cycle 0 with the block idle and nothing pending:
  - `pending` bit set at cycle 1.
  - START (with `op_start`) at cycle 2, with `op_sel` valid.
  - WAIT from cycle 3.
- `op_done` sampled at WAIT cycle k → DONE at k+1, status updated at k+2, IDLE at k+2.
- Earliest next `op_start` is k+3 if anything is pending.
- Timeout: WAIT is entered at cycle w; `status_timeout` is high and the state is IDLE at cycle w+TIMEOUT_CYCLES.
- Abort: `w_reset` strobe at cycle a → IDLE at a+1 → START for op 0 at a+2.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `com_op_code_pkg` holds:
  - the op-index localparams OP_W_RESET=0 … OP_W_EXECUTE=14, matching the decoder output order;
  - N_OP;
  - the state enum `seq_state_t`.
- Sub-module `com_op_code_prio_enc`: N_OP-bit lowest-index-first priority encoder, producing a 4-bit index plus a valid bit.

## Test plan
- Single-op handshake: `req[5]` strobe, then `op_done` on the 4th WAIT cycle.
  - Expect `op_start` at cycle 2 with `op_sel=5`.
  - Expect `status_done=1` and `last_op=5`.
  - Expect `busy` low afterwards.
- Priority: `req[9]` and `req[2]` in the same cycle, `op_done` after each dispatch.
  - Expect `op_sel=2` dispatched first, then 9.
  - `pending` goes 0x204 → 0x200 → 0.
- Timeout: TIMEOUT_CYCLES=8, `req[3]`, `op_done` held low.
  - Expect `status_timeout=1` exactly 8 cycles after WAIT entry, then IDLE.
  - Expect `status_done=0`.
- Error/done collision and clear: `op_error` and `op_done` together in WAIT.
  - Expect `status_error=1` and `status_done=0`.
  - Then `req[13]` → all flags 0 next cycle, with no `op_start`.
- Abort: `req[6]` and `req[8]`; during WAIT of op 6, `req[0]`.
  - Expect IDLE next cycle and `pending=0x001`.
  - Expect op 0 dispatched; op 8 dropped.
- Async reset mid-WAIT: assert `reset` between edges.
  - Expect all outputs 0 immediately and the state IDLE.
  - `op_done` arriving after `reset` is deasserted is ignored.
